draw_request_arbiter: RTL

//  Shares the single sprite drawer between up to NUM_REQ draw requesters (character BG-erase,

---
 rtl/draw_pkg.sv | 21 ++
 rtl/draw_request_arbiter_rr_pick.sv | 30 +++
 rtl/draw_request_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared constants for the sprite-draw path: arbiter state encoding, screen coordinate widths
// and the sprite IDs used by the requesters.
package draw_pkg;

   localparam int X_W   = 9;
   localparam int Y_W   = 8;
   localparam int SPR_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } draw_state_e;

   localparam logic [SPR_W-1:0] SPR_BG       = 3'd0;
   localparam logic [SPR_W-1:0] SPR_CHAR     = 3'd1;
   localparam logic [SPR_W-1:0] SPR_PLATFORM = 3'd2;
   localparam logic [SPR_W-1:0] SPR_DOOR     = 3'd3;

endpackage

// File: rtl/draw_request_arbiter_rr_pick.sv
// Round-robin winner selection: first set request bit scanning upward from rr_ptr, wrapping.
// Purely combinational.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [IDX_W-1:0]   win_idx,
   output logic               win_valid
);

   always_comb begin
      int cand;
      cand       = 0;
      win_onehot = '0;
      win_idx    = '0;
      win_valid  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(rr_ptr) + i) % NUM_REQ;
         if (!win_valid && req[cand]) begin
            win_valid        = 1'b1;
            win_idx          = IDX_W'(cand);
            win_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/draw_request_arbiter.sv
// Shares the sprite drawer between NUM_REQ requesters: round-robin grant, coordinate latch,
// drawStart pulse, watchdog on drawDone, per-requester done pulse.
//   state      | meaning
//   ST_IDLE    | no owner; arbitrate when any req is high
//   ST_ISSUE   | owner latched; drawStart pulses next cycle
//   ST_WAIT    | drawer busy; watchdog counting
//   ST_RELEASE | done pulse visible; grant drops next cycle
module draw_request_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SPR_W   = draw_pkg::SPR_W,
   parameter int TIMEOUT = 131072
) (
   input  logic                                clock,
   input  logic                                resetn,
   input  logic [NUM_REQ-1:0]                  req,
   input  logic [draw_pkg::X_W*NUM_REQ-1:0]    reqX,
   input  logic [draw_pkg::Y_W*NUM_REQ-1:0]    reqY,
   input  logic [SPR_W*NUM_REQ-1:0]            reqSprite,
   input  logic                                drawDone,
   output logic [NUM_REQ-1:0]                  grant,
   output logic [NUM_REQ-1:0]                  done,
   output logic                                drawStart,
   output logic [draw_pkg::X_W-1:0]            drawX,
   output logic [draw_pkg::Y_W-1:0]            drawY,
   output logic [SPR_W-1:0]                    drawSprite,
   output logic                                timeoutErr
);
   import draw_pkg::*;

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   draw_state_e        state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               draw_start_q, draw_start_d;
   logic [X_W-1:0]     draw_x_q, draw_x_d;
   logic [Y_W-1:0]     draw_y_q, draw_y_d;
   logic [SPR_W-1:0]   draw_spr_q, draw_spr_d;
   logic               timeout_err_q, timeout_err_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
   logic               draw_done_prev_q, draw_done_prev_d;

   logic [NUM_REQ-1:0] win_onehot;
   logic [IDX_W-1:0]   win_idx;
   logic               win_valid;
   logic               done_seen;
   logic [IDX_W-1:0]   next_ptr;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req        (req),
      .rr_ptr     (rr_ptr_q),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .win_valid  (win_valid)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q          <= ST_IDLE;
         grant_q          <= '0;
         done_q           <= '0;
         draw_start_q     <= 1'b0;
         draw_x_q         <= '0;
         draw_y_q         <= '0;
         draw_spr_q       <= SPR_W'(SPR_BG);
         timeout_err_q    <= 1'b0;
         rr_ptr_q         <= '0;
         owner_q          <= '0;
         wd_cnt_q         <= '0;
         draw_done_prev_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         grant_q          <= grant_d;
         done_q           <= done_d;
         draw_start_q     <= draw_start_d;
         draw_x_q         <= draw_x_d;
         draw_y_q         <= draw_y_d;
         draw_spr_q       <= draw_spr_d;
         timeout_err_q    <= timeout_err_d;
         rr_ptr_q         <= rr_ptr_d;
         owner_q          <= owner_d;
         wd_cnt_q         <= wd_cnt_d;
         draw_done_prev_q <= draw_done_prev_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      done_d           = '0;
      draw_start_d     = 1'b0;
      draw_x_d         = draw_x_q;
      draw_y_d         = draw_y_q;
      draw_spr_d       = draw_spr_q;
      timeout_err_d    = timeout_err_q;
      rr_ptr_d         = rr_ptr_q;
      owner_d          = owner_q;
      wd_cnt_d         = wd_cnt_q;
      draw_done_prev_d = drawDone;
      // drawDone may be held as a level; only its first high cycle ends a draw
      done_seen        = drawDone & ~draw_done_prev_q;
      next_ptr         = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               grant_d    = win_onehot;
               owner_d    = win_idx;
               draw_x_d   = reqX[int'(win_idx)*X_W +: X_W];
               draw_y_d   = reqY[int'(win_idx)*Y_W +: Y_W];
               draw_spr_d = reqSprite[int'(win_idx)*SPR_W +: SPR_W];
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            draw_start_d = 1'b1;
            wd_cnt_d     = '0;
            state_d      = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_seen) begin
               done_d   = grant_q;
               rr_ptr_d = next_ptr;
               state_d  = ST_RELEASE;
            end else if (wd_cnt_q == WD_LAST) begin
               timeout_err_d = 1'b1;
               done_d        = grant_q;
               rr_ptr_d      = next_ptr;
               state_d       = ST_RELEASE;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign drawStart  = draw_start_q;
   assign drawX      = draw_x_q;
   assign drawY      = draw_y_q;
   assign drawSprite = draw_spr_q;
   assign timeoutErr = timeout_err_q;

endmodule
